// File: rtl/key_cfg_if.sv
// Configuration handshake bus between key_cfg_ctrl (master) and the pipeline config input (slave).
interface key_cfg_if #(
    parameter int MODE_W   = 2,
    parameter int THRESH_W = 8
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [MODE_W-1:0]   cfg_mode;
    logic [THRESH_W-1:0] cfg_thresh;

    modport master (output cfg_valid, output cfg_mode, output cfg_thresh, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_mode, input cfg_thresh, output cfg_ready);
endinterface

// File: rtl/key_cfg_ctrl.sv
// Key-driven mode/threshold editor; shadow edits are committed to the pipeline
// only on a frame edge through a valid/ready handshake.
module key_cfg_ctrl #(
    parameter int MODE_NUM    = 4,
    parameter int MODE_W      = 2,
    parameter int THRESH_W    = 8,
    parameter int THRESH_DEF  = 64,
    parameter int THRESH_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_flag,
    input  logic [2:0]       key_value,
    input  logic             frame_vsync,
    key_cfg_if.master        cfg,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, SEND} state_t;

    localparam logic [THRESH_W:0]   STEP     = (THRESH_W+1)'(THRESH_STEP);
    localparam logic [THRESH_W:0]   TH_MAX   = {1'b0, {THRESH_W{1'b1}}};
    localparam logic [THRESH_W-1:0] TH_DEF   = THRESH_W'(THRESH_DEF);
    localparam logic [MODE_W-1:0]   MODE_TOP = MODE_W'(MODE_NUM - 1);

    state_t              state;
    logic [MODE_W-1:0]   sh_mode, mode_nxt;
    logic [THRESH_W-1:0] sh_thresh, thr_nxt;
    logic [THRESH_W:0]   thr_ext, up_sum;
    logic                dirty, vsync_d, frame_edge, key_chg;

    assign frame_edge = frame_vsync & ~vsync_d;
    assign thr_ext    = {1'b0, sh_thresh};
    assign up_sum     = thr_ext + STEP;

    // Saturating one-hot key decode; anything not exactly one-hot is a no-op.
    always_comb begin
        mode_nxt = sh_mode;
        thr_nxt  = sh_thresh;
        case (key_value)
            3'b001: mode_nxt = (sh_mode == MODE_TOP) ? '0 : sh_mode + 1'b1;
            3'b010: thr_nxt  = (up_sum > TH_MAX) ? TH_MAX[THRESH_W-1:0] : up_sum[THRESH_W-1:0];
            3'b100: thr_nxt  = (thr_ext < STEP) ? '0 : sh_thresh - STEP[THRESH_W-1:0];
            default: ;
        endcase
        key_chg = (mode_nxt != sh_mode) || (thr_nxt != sh_thresh);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            cfg.cfg_valid  <= 1'b0;
            cfg.cfg_mode   <= '0;
            cfg.cfg_thresh <= TH_DEF;
            sh_mode        <= '0;
            sh_thresh      <= TH_DEF;
            dirty          <= 1'b1;
            vsync_d        <= 1'b0;
        end else begin
            vsync_d <= frame_vsync;
            if (key_flag) begin
                sh_mode   <= mode_nxt;
                sh_thresh <= thr_nxt;
            end
            case (state)
                IDLE: if (dirty) begin
                    state <= WAIT_FRAME;
                    busy  <= 1'b1;
                end
                WAIT_FRAME: if (frame_edge) begin
                    cfg.cfg_mode   <= sh_mode;
                    cfg.cfg_thresh <= sh_thresh;
                    cfg.cfg_valid  <= 1'b1;
                    dirty          <= 1'b0;
                    state          <= SEND;
                end
                SEND: if (cfg.cfg_ready) begin
                    cfg.cfg_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // A real edit in the snapshot cycle must survive the snapshot's clear.
            if (key_flag && key_chg)
                dirty <= 1'b1;
        end
    end
endmodule
